// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add/sub/inc/dec, shifts, logic, compares) return a
// result one cycle after acceptance. MUL is an iterative shift-add that
// takes WIDTH+1 cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation request / block can accept this cycle
//   A, B, Opcode        operands (B doubles as shift amount), op select
//   out_valid/out_ready result valid / consumer accepts result
//   result              registered result
//   carry, overflow     carry/borrow and overflow flags
//   zero, negative      derived from result
//   busy                multiply in progress
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_INC = 4'h2, OP_DEC = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_SRA = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_NOR = 4'hB;
  localparam logic [3:0] OP_EQ  = 4'hC, OP_NE  = 4'hD, OP_GT  = 4'hE, OP_LT  = 4'hF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q, busy_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q, overflow_q, zero_q, negative_q;

  logic [2*WIDTH-1:0] mcand_q, acc_q;
  logic [WIDTH-1:0]   mplier_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_c_d, alu_v_d, sh_big;
  logic               accept, mul_start;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (Opcode == OP_MUL);

  // Stage: combinational evaluation of single-cycle ops on live inputs
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    // Shift amount uses the full B; anything >= WIDTH saturates the shift.
    sh_big    = (B >= WIDTH_V);
    case (Opcode)
      OP_ADD: begin
        {alu_c_d, alu_res_d} = {1'b0, A} + {1'b0, B};
        alu_v_d = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res_d[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // Extended MSB of the difference is the borrow (A < B unsigned).
        {alu_c_d, alu_res_d} = {1'b0, A} - {1'b0, B};
        alu_v_d = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res_d[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        {alu_c_d, alu_res_d} = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        alu_v_d = !A[WIDTH-1] && alu_res_d[WIDTH-1];
      end
      OP_DEC: begin
        {alu_c_d, alu_res_d} = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
        alu_v_d = A[WIDTH-1] && !alu_res_d[WIDTH-1];
      end
      OP_SHL: alu_res_d = sh_big ? '0 : (A << B);
      OP_SHR: alu_res_d = sh_big ? '0 : (A >> B);
      OP_SRA: alu_res_d = sh_big ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> B);
      OP_AND: alu_res_d = A & B;
      OP_OR:  alu_res_d = A | B;
      OP_XOR: alu_res_d = A ^ B;
      OP_NOR: alu_res_d = ~(A | B);
      OP_EQ:  alu_res_d = {{(WIDTH-1){1'b0}}, (A == B)};
      OP_NE:  alu_res_d = {{(WIDTH-1){1'b0}}, (A != B)};
      OP_GT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      OP_LT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res_d = '0; // MUL result comes from the accumulator
    endcase
  end

  // Stage: control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      // A consumed result retires unless overwritten below in the same cycle.
      if (out_valid_q && out_ready)
        out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (accept) begin
            result_q    <= alu_res_d;
            carry_q     <= alu_c_d;
            overflow_q  <= alu_v_d;
            zero_q      <= (alu_res_d == '0);
            negative_q  <= alu_res_d[WIDTH-1];
            out_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          result_q    <= acc_q[WIDTH-1:0];
          carry_q     <= 1'b0;
          overflow_q  <= |acc_q[2*WIDTH-1:WIDTH];
          zero_q      <= (acc_q[WIDTH-1:0] == '0);
          negative_q  <= acc_q[WIDTH-1];
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage: shift-add multiply datapath; multiplicand walks left while the
  // multiplier walks right, so bit 0 of the multiplier selects each add.
  // Restarting a multiply clears the accumulator, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand_q  <= {{WIDTH{1'b0}}, A};
      mplier_q <= B;
      acc_q    <= '0;
    end else if (state_q == BUSY) begin
      if (mplier_q[0])
        acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign busy      = busy_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU/comparator/logical units.
- Accepts one operation per valid/ready handshake and returns a registered result with status flags.
- Adds arithmetic, shift and a multi-cycle shift-add multiply.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B, or shift amount.
- Opcode  input  4  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- carry  output  1  carry/borrow flag.
- overflow  output  1  signed overflow (ADD/SUB/INC/DEC) or unsigned product overflow (MUL).
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- busy  output  1  multiply in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0; carry=0; overflow=0; zero=0; negative=0.
  - Reset mid-multiply discards the operation and its partial product.
- Opcode map:
  - 0000 ADD A+B.
  - 0001 SUB A-B. carry=1 means borrow, i.e. A<B unsigned.
  - 0010 INC A+1.
  - 0011 DEC A-1.
  - 0100 MUL: unsigned, low WIDTH bits of A*B.
  - 0101 SHL A<<B.
  - 0110 SHR A>>B, logical.
  - 0111 SRA A>>>B, arithmetic.
  - 1000 AND, 1001 OR, 1010 XOR, 1011 NOR.
  - 1100 EQ, 1101 NE, 1110 signed A>B, 1111 signed A<B. Compare result is 1 or 0, zero-extended to WIDTH.
- Shift boundary, B unsigned, full width used:
  - B>=WIDTH: SHL/SHR give 0; SRA gives all bits = A[WIDTH-1].
  - B=0 passes A.
- Flags:
  - carry and overflow are meaningful for 0000-0011.
  - MUL: carry=0; overflow=1 iff the upper WIDTH product bits are nonzero.
  - All other opcodes: carry=0 and overflow=0.
  - zero and negative are always derived from result.
- Handshake:
  - Acceptance: in_valid && in_ready on a rising edge; A, B and Opcode are captured at that edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A new operation may be accepted in the same cycle the previous result is consumed.
  - Result transfer: out_valid && out_ready. out_valid then drops the next edge, unless a single-cycle op was accepted in that cycle, in which case it stays high with new data.
  - While out_valid=1 and out_ready=0: result and flags are held stable and in_ready=0.
- States:
  - IDLE: single-cycle op accepted -> result registered at the acceptance edge; out_valid=1 the following cycle (latency 1); stays IDLE.
  - IDLE: MUL accepted -> BUSY; busy=1; counter=0; product accumulator cleared.
  - BUSY: each cycle, if multiplier bit[counter] is set, add A<<counter to the 2*WIDTH accumulator; counter+1. After WIDTH iterations -> DONE.
  - DONE: register result/flags; out_valid=1; busy=0; -> IDLE.
  - MUL latency: out_valid asserts WIDTH+1 cycles after the acceptance edge.
- Illegal input: none; all 16 opcodes are defined. in_valid while in_ready=0 is ignored, and the source must hold it.

Test Plan:
- WIDTH=8, ADD A=0x7F B=0x01, out_ready=1 -> one cycle later: result=0x80, carry=0, overflow=1, negative=1, zero=0.
- SUB A=0x03 B=0x05 -> result=0xFE, carry=1 (borrow), overflow=0. Follow with EQ A=B=0x5A -> result=0x01. Then signed GT A=0x80 B=0x01 -> result=0x00.
- MUL A=0x10 B=0x11 -> busy high for 8 cycles, in_ready=0 throughout; out_valid on cycle 9 with result=0x10, overflow=1. MUL A=0x0F B=0x03 -> result=0x2D, overflow=0.
- Shifts, A=0x96: SRA with B=3 -> 0xF2; SRA with B=9 -> 0xFF; SHR with B=8 -> 0x00; SHL with B=0 -> 0x96.
- Back-pressure:
  - Hold out_ready=0 after NOR A=0x0F B=0xF0 (result=0x00, zero=1): result and flags stay stable and in_ready=0 for 5 cycles.
  - Then raise out_ready while in_valid=1 with XOR A=0xFF B=0x0F: result 0xF0 appears the next cycle with no bubble.
- Pull rst_n low 4 cycles into a MUL -> all outputs return to reset values immediately, in_ready=1. After release, ADD 0x01+0x01 -> result=0x02.
